adc_uart_streamer: RTL

Parametrised successor to the single-channel ADC-to-UART path. It accepts channel-tagged ADC samples, decimates them per channel, and buffers them in an internal FIFO. It then serialises each sample into a framed byte packet for the existing uart_tx handshake (tx_enable/tx_data/tx_available). It sits between the ADC front-end(s) and uart_tx in top.

---
 rtl/adc_uart_streamer_pkg.sv | 23 ++
 rtl/adc_uart_streamer_sync_fifo.sv | 63 ++++++
 rtl/adc_uart_streamer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_uart_streamer_pkg.sv
// Shared definitions for the ADC-to-UART streamer: FSM state encodings,
// packet geometry, default sync byte and the packet checksum helper.
package adc_uart_streamer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SEND      = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  localparam int PKT_LEN_BASE = 4;
  localparam int CKSUM_IDX    = 4;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // XOR of channel, data-high and data-low bytes (header is excluded).
  function automatic logic [7:0] pkt_checksum(input logic [7:0] ch_b,
                                              input logic [7:0] hi_b,
                                              input logic [7:0] lo_b);
    return ch_b ^ hi_b ^ lo_b;
  endfunction

endpackage

// File: rtl/adc_uart_streamer_sync_fifo.sv
// sync_fifo: single-clock FIFO with power-of-2 depth. The head entry is
// presented on rd_data straight out of the register array, so a pop can
// capture it on the same edge. A write to a full FIFO succeeds when a read
// happens in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == {(AW+1){1'b0}});
  assign do_rd_s = rd_en && !empty;
  assign do_wr_s = wr_en && (!full || do_rd_s);
  assign rd_data = mem_r[rd_ptr_r];
  assign level   = count_r;

  // Storage array; contents need no reset since count_r guards validity.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/adc_uart_streamer.sv
// adc_uart_streamer: decimates channel-tagged ADC samples per channel,
// buffers them as {ch, data} in a sync_fifo and serialises each entry into
// a framed byte packet (HEADER, ch, data[15:8], data[7:0]) for uart_tx.
// Build option STREAMER_CHECKSUM_EN appends an XOR checksum byte.
module adc_uart_streamer
  import adc_uart_streamer_pkg::*;
#(
  parameter  int         ADC_WIDTH  = 10,
  parameter  int         NUM_CH     = 2,
  parameter  int         FIFO_DEPTH = 16,
  parameter  int         DECIM      = 1,
  parameter  logic [7:0] HEADER     = HEADER_DEFAULT,
  localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [ADC_WIDTH-1:0]          sample_data,
  input  logic [CH_W-1:0]               sample_ch,
  input  logic                          sample_valid,
  output logic [7:0]                    tx_data,
  output logic                          tx_enable,
  input  logic                          tx_available,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_count,
  output logic                          busy
);

  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int FW     = CH_W + ADC_WIDTH;
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
`ifdef STREAMER_CHECKSUM_EN
  localparam int PKT_LEN = PKT_LEN_BASE + 1;
`else
  localparam int PKT_LEN = PKT_LEN_BASE;
`endif
  localparam logic [DCNT_W-1:0] DEC_LAST = DCNT_W'(DECIM - 1);
  localparam logic [2:0]        LAST_IDX = 3'(PKT_LEN - 1);

  logic [DCNT_W-1:0] dec_cnt_r [NUM_CH];
  logic              ch_ok_s;
  logic              keep_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              ovf_inc_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [FW-1:0]     rd_data_s;
  logic [LVL_W-1:0]  fifo_level_s;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [2:0]        byte_idx_r;
  logic [2:0]        send_idx_s;
  logic              send_s;
  logic [FW-1:0]     pkt_r;
  logic [15:0]       data16_s;
  logic [7:0]        ch_byte_s;
  logic [7:0]        byte_s;
  logic [7:0]        tx_data_r;
  logic              tx_enable_r;
  logic [15:0]       overflow_r;
  logic              busy_r;

  // Intake qualification: valid channel while enabled, kept when its counter is 0.
  always_comb begin
    ch_ok_s = 1'b0;
    keep_s  = 1'b0;
    if (sample_valid && enable && (int'(sample_ch) < NUM_CH)) begin
      ch_ok_s = 1'b1;
      keep_s  = (dec_cnt_r[sample_ch] == {DCNT_W{1'b0}});
    end else begin
      ch_ok_s = 1'b0;
      keep_s  = 1'b0;
    end
  end

  assign rd_en_s   = (state_r == ST_IDLE) && !fifo_empty_s && tx_available;
  assign wr_en_s   = keep_s && (!fifo_full_s || rd_en_s);
  assign ovf_inc_s = keep_s && fifo_full_s && !rd_en_s;

  // Per-channel decimation counters wrapping at DECIM-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        dec_cnt_r[i] <= {DCNT_W{1'b0}};
      end
    end else if (ch_ok_s) begin
      dec_cnt_r[sample_ch] <= (dec_cnt_r[sample_ch] == DEC_LAST) ?
                              {DCNT_W{1'b0}} : dec_cnt_r[sample_ch] + DCNT_W'(1);
    end
  end

  // Saturating count of kept samples lost to a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 16'h0000;
    end else if (ovf_inc_s && (overflow_r != 16'hFFFF)) begin
      overflow_r <= overflow_r + 16'h0001;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_data ({sample_ch, sample_data}),
    .rd_en   (rd_en_s),
    .rd_data (rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level_s)
  );

  // Packet FSM next state and which byte (if any) is launched next cycle.
  always_comb begin
    state_nxt_s = state_r;
    send_s      = 1'b0;
    send_idx_s  = byte_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_en_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_SEND;
        send_s      = 1'b1;
        send_idx_s  = 3'd0;
      end
      ST_SEND: begin
        state_nxt_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!tx_available) begin
          state_nxt_s = ST_WAIT_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_IDLE: begin
        if (tx_available && (byte_idx_r == LAST_IDX)) begin
          state_nxt_s = ST_IDLE;
        end else if (tx_available) begin
          state_nxt_s = ST_SEND;
          send_s      = 1'b1;
          send_idx_s  = byte_idx_r + 3'd1;
        end else begin
          state_nxt_s = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Byte selection from the packet register.
  always_comb begin
    data16_s                  = {16{1'b0}};
    data16_s[ADC_WIDTH-1:0]   = pkt_r[ADC_WIDTH-1:0];
    ch_byte_s                 = 8'(pkt_r[FW-1:ADC_WIDTH]);
    case (send_idx_s)
      3'd0:    byte_s = HEADER;
      3'd1:    byte_s = ch_byte_s;
      3'd2:    byte_s = data16_s[15:8];
      3'd3:    byte_s = data16_s[7:0];
`ifdef STREAMER_CHECKSUM_EN
      3'(CKSUM_IDX): byte_s = pkt_checksum(ch_byte_s, data16_s[15:8], data16_s[7:0]);
`endif
      default: byte_s = 8'h00;
    endcase
  end

  // FSM state, packet capture and registered UART-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      byte_idx_r  <= 3'd0;
      pkt_r       <= {FW{1'b0}};
      tx_data_r   <= 8'h00;
      tx_enable_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (rd_en_s) begin
        pkt_r <= rd_data_s;
      end
      if (send_s) begin
        byte_idx_r <= send_idx_s;
        tx_data_r  <= byte_s;
      end
      tx_enable_r <= send_s;
      busy_r      <= (state_nxt_s != ST_IDLE) || wr_en_s ||
                     (fifo_level_s > LVL_W'(rd_en_s));
    end
  end

  assign tx_data        = tx_data_r;
  assign tx_enable      = tx_enable_r;
  assign fifo_level     = fifo_level_s;
  assign overflow_count = overflow_r;
  assign busy           = busy_r;

endmodule
